letter_scheduler: RTL and testbench
===================================

Name: letter_scheduler

Overview:
- Game controller that sequences the three falling-letter lanes feeding the 40x30 letter framebuffer renderer.
- Spawns pseudo-random 8-bit targets and advances each lane's row on a divided game tick.
- Matches the player's switch guess against active lanes, and tracks score, lives and game-over.
- Sits between the board I/O (switches, key, 50 MHz clock) and the renderer's letter1..3/ypos1..3 inputs.

Parameters:
TICK_DIV, 5000000, clock cycles per game tick (10 Hz at 50 MHz)
SPAWN_GAP, 8, game ticks between spawn attempts
BOTTOM_ROW, 21, last visible ypos; a lane advancing past it is a miss
START_LIVES, 3, lives loaded at reset (max 3)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = game runs; 0 = tick divider and spawn counter hold
guess  in  8  player switch value
guess_valid  in  1  single-cycle pulse, debounced submit key
letter1, letter2, letter3  out  8  lane target value to renderer
ypos1, ypos2, ypos3  out  5  lane row; 31 = blank (renderer blanks any row >= 22)
score  out  8  hits, saturating at 255
lives  out  2  remaining lives
game_over  out  1  sticky end-of-game flag

Behaviour:
- One clock; reset is asynchronous and active-low. All state is held in flops cleared by reset_n low.
- Reset values:
  - letters 0, ypos 31, all lanes IDLE
  - score 0, lives START_LIVES, game_over 0
  - tick counter 0, spawn counter SPAWN_GAP-1, LFSR 8'hA5
- All outputs are registered. An event in cycle N is visible in cycle N+1.
- Tick divider:
  - Counts 0..TICK_DIV-1 while enable=1 and game_over=0.
  - tick=1 in the cycle the count equals TICK_DIV-1; the count then wraps to 0.
- Per-lane FSM:
  - IDLE: ypos=31. Goes to FALL on spawn.
  - FALL: on tick, ypos<BOTTOM_ROW increments ypos. ypos==BOTTOM_ROW goes to IDLE (ypos=31) and counts a miss.
- Spawn:
  - On tick the spawn counter advances.
  - When it reaches SPAWN_GAP-1, it wraps to 0. If any lane was IDLE at the start of that cycle, the lowest-index IDLE lane loads letter=LFSR and ypos=0.
  - The LFSR advances only on a successful spawn: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - No idle lane means the spawn is skipped and the LFSR is unchanged.
  - A lane freed by a miss in the same cycle is not eligible for that spawn.
  - A freshly spawned lane does not advance in its spawn cycle.
- Hit:
  - guess_valid=1 and guess equal to the letter of a FALL lane: the lowest-index matching lane goes to IDLE (ypos=31) and score increments (saturating).
  - Only one lane is cleared per pulse.
  - A non-matching guess has no effect.
  - guess_valid is honoured regardless of tick and enable, but ignored when game_over=1.
- Simultaneous hit and tick miss on the same lane: the hit wins; no miss, score+1.
- Misses:
  - Each miss decrements lives; multiple lanes missing on one tick each decrement.
  - lives floors at 0.
  - lives reaching 0 sets game_over.
- game_over=1:
  - All lanes forced IDLE with ypos 31, letters unchanged.
  - Counters, score and lives freeze until reset_n.
- reset_n asserted mid-game returns everything to the reset values immediately.

Decomposition:
- Package flippy_pkg holds:
  - lane_state_t enum {IDLE, FALL}
  - BLANK_Y=5'd31
  - LFSR_SEED=8'hA5
  - the LFSR tap mask
- Sub-module lfsr8 (seedable, advance-enable input, 8-bit state out).
- Lane FSMs are three instances of the same always block, or a generate loop over a 3-entry array.

Test Plan (TICK_DIV=4, SPAWN_GAP=2, enable=1):
1. Reset, no activity -> ypos1..3=31, score=0, lives=3, game_over=0, letters=0.
2. Spawn sequence -> first tick (cycle 4) gives letter1=8'hA5, ypos1=0. Two ticks later letter2=8'h4A, ypos2=0, and ypos1=2 by then.
3. Hit: guess=8'hA5 with guess_valid while lane1 is falling -> next cycle ypos1=31, score=1, lives=3. guess=8'h00 pulse -> no change.
4. Miss: let lane1 reach ypos 21, then next tick -> ypos1=31, lives=2, score unchanged.
5. Hit/miss race: guess_valid with the correct letter on the same cycle lane1 at ypos 21 sees tick -> score+1, lives unchanged.
6. Game over: three misses with no guesses -> lives=0, game_over=1, all ypos=31. A later correct guess and further ticks leave all outputs frozen. reset_n low restores the reset values.

Source files
------------

// File: rtl/flippy_pkg.sv
// flippy_pkg: lane state type, blank row, LFSR seed and taps shared by the letter scheduler
package flippy_pkg;
    typedef enum logic {IDLE, FALL} lane_state_t;
    localparam logic [4:0] BLANK_Y = 5'd31;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/letter_scheduler_lfsr8.sv
// lfsr8: seedable 8-bit Fibonacci LFSR that steps only when advance is high
module lfsr8 import flippy_pkg::*; #(
    parameter logic [7:0] SEED = LFSR_SEED
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       advance,
    output logic [7:0] state
);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= SEED;
        else if (advance) state <= lfsr_next(state);
endmodule

// File: rtl/letter_scheduler.sv
// letter_scheduler: spawns, advances and scores three falling-letter lanes for the renderer
module letter_scheduler import flippy_pkg::*; #(
    parameter int TICK_DIV    = 5000000,
    parameter int SPAWN_GAP   = 8,
    parameter int BOTTOM_ROW  = 21,
    parameter int START_LIVES = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] guess,
    input  logic       guess_valid,
    output logic [7:0] letter1,
    output logic [7:0] letter2,
    output logic [7:0] letter3,
    output logic [4:0] ypos1,
    output logic [4:0] ypos2,
    output logic [4:0] ypos3,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int SW = SPAWN_GAP > 1 ? $clog2(SPAWN_GAP) : 1;
    lane_state_t   st_q [3], st_d [3];
    logic [4:0]    y_q [3], y_d [3];
    logic [7:0]    ltr_q [3], ltr_d [3];
    logic [TW-1:0] tick_q, tick_d;
    logic [SW-1:0] gap_q, gap_d;
    logic [7:0]    score_q, score_d, rnd;
    logic [1:0]    lives_q, lives_d, nmiss;
    logic          over_q, over_d, run, tick, spawn_ok, adv;
    logic [2:0]    idle, match, hit, miss, sp;

    lfsr8 u_lfsr (.clock(clock), .reset_n(reset_n), .advance(adv), .state(rnd));

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                st_q[i]  <= IDLE;
                y_q[i]   <= BLANK_Y;
                ltr_q[i] <= '0;
            end
            tick_q  <= '0;
            gap_q   <= SW'(SPAWN_GAP - 1);
            score_q <= '0;
            lives_q <= 2'(START_LIVES);
            over_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            y_q     <= y_d;
            ltr_q   <= ltr_d;
            tick_q  <= tick_d;
            gap_q   <= gap_d;
            score_q <= score_d;
            lives_q <= lives_d;
            over_q  <= over_d;
        end

    always_comb begin
        run = enable && !over_q;
        tick = run && tick_q == TW'(TICK_DIV - 1);
        tick_d = !run ? tick_q : tick ? '0 : tick_q + 1'b1;
        gap_d = !tick ? gap_q : gap_q == SW'(SPAWN_GAP - 1) ? '0 : gap_q + 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle[i]  = st_q[i] == IDLE;
            match[i] = guess_valid && !over_q && st_q[i] == FALL && ltr_q[i] == guess;
        end
        // lowest-index winners: isolate the least significant set bit
        hit = match & (~match + 3'd1);
        spawn_ok = tick && gap_q == SW'(SPAWN_GAP - 1) && |idle;
        sp = spawn_ok ? idle & (~idle + 3'd1) : 3'd0;
        for (int i = 0; i < 3; i++)
            miss[i] = tick && st_q[i] == FALL && y_q[i] == 5'(BOTTOM_ROW) && !hit[i];
        nmiss = 2'(miss[0]) + 2'(miss[1]) + 2'(miss[2]);
        lives_d = lives_q > nmiss ? lives_q - nmiss : 2'd0;
        over_d = over_q || lives_d == 2'd0;
        score_d = (|hit && score_q != 8'hFF) ? score_q + 8'd1 : score_q;
        adv = |sp && !over_d;
        for (int i = 0; i < 3; i++) begin
            st_d[i]  = st_q[i];
            y_d[i]   = y_q[i];
            ltr_d[i] = ltr_q[i];
            if (over_d || hit[i] || miss[i]) begin
                st_d[i] = IDLE;
                y_d[i]  = BLANK_Y;
            end else if (sp[i]) begin
                st_d[i]  = FALL;
                y_d[i]   = 5'd0;
                ltr_d[i] = rnd;
            end else if (tick && st_q[i] == FALL) begin
                y_d[i] = y_q[i] + 5'd1;
            end
        end
    end

    always_comb begin
        letter1   = ltr_q[0];
        letter2   = ltr_q[1];
        letter3   = ltr_q[2];
        ypos1     = y_q[0];
        ypos2     = y_q[1];
        ypos3     = y_q[2];
        score     = score_q;
        lives     = lives_q;
        game_over = over_q;
    end
endmodule

// File: tb/tb_letter_scheduler.sv
// tb_letter_scheduler: directed timeline with TICK_DIV=4, SPAWN_GAP=2 (tick k lands on edge 4k)
module tb_letter_scheduler;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] guess = '0;
    logic       guess_valid = 1'b0;
    logic [7:0] letter1, letter2, letter3, score;
    logic [4:0] ypos1, ypos2, ypos3;
    logic [1:0] lives;
    logic       game_over;
    int tests = 0, fails = 0, edges = 0;

    letter_scheduler #(.TICK_DIV(4), .SPAWN_GAP(2), .BOTTOM_ROW(21), .START_LIVES(3)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .guess(guess),
        .guess_valid(guess_valid), .letter1(letter1), .letter2(letter2), .letter3(letter3),
        .ypos1(ypos1), .ypos2(ypos2), .ypos3(ypos3), .score(score), .lives(lives),
        .game_over(game_over)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_to(input int e);
        while (edges < e) begin
            @(posedge clock);
            edges++;
        end
        @(negedge clock);
    endtask

    task automatic pulse(input logic [7:0] g, input int e);
        guess = g;
        guess_valid = 1'b1;
        run_to(e);
        guess_valid = 1'b0;
        guess = '0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_y1"}, ypos1, 31);
        check({tag, "_y2"}, ypos2, 31);
        check({tag, "_y3"}, ypos3, 31);
        check({tag, "_l1"}, letter1, 0);
        check({tag, "_l2"}, letter2, 0);
        check({tag, "_l3"}, letter3, 0);
        check({tag, "_score"}, score, 0);
        check({tag, "_lives"}, lives, 3);
        check({tag, "_over"}, game_over, 0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_reset("rst");
        reset_n = 1'b1;
        run_to(3);
        check("pre_tick_y1", ypos1, 31);
        run_to(4);
        check("spawn1_letter", letter1, 8'hA5);
        check("spawn1_y", ypos1, 0);
        run_to(12);
        check("spawn2_letter", letter2, 8'h4A);
        check("spawn2_y", ypos2, 0);
        check("lane1_fall", ypos1, 2);
        pulse(8'hA5, 13);
        check("hit_y1", ypos1, 31);
        check("hit_score", score, 1);
        check("hit_lives", lives, 3);
        pulse(8'h00, 14);
        check("nohit_score", score, 1);
        check("nohit_y2", ypos2, 0);
        run_to(20);
        check("respawn_letter", letter1, 8'h95);
        check("respawn_y1", ypos1, 0);
        check("lane2_y", ypos2, 2);
        run_to(28);
        check("spawn3_letter", letter3, 8'h2A);
        check("spawn3_y", ypos3, 0);
        run_to(96);
        check("bottom_y2", ypos2, 21);
        check("bottom_lives", lives, 3);
        run_to(100);
        check("miss_y2", ypos2, 31);
        check("miss_lives", lives, 2);
        check("miss_score", score, 1);
        check("miss_y1", ypos1, 20);
        run_to(104);
        check("freed_no_spawn", ypos2, 31);
        check("race_setup_y1", ypos1, 21);
        run_to(107);
        pulse(8'h95, 108);
        check("race_y1", ypos1, 31);
        check("race_score", score, 2);
        check("race_lives", lives, 2);
        check("race_spawn_letter", letter2, 8'h54);
        check("race_spawn_y", ypos2, 0);
        run_to(116);
        check("miss3_lives", lives, 1);
        check("miss3_y3", ypos3, 31);
        check("spawn_a9", letter1, 8'hA9);
        run_to(195);
        check("pre_over_flag", game_over, 0);
        check("pre_over_y2", ypos2, 21);
        run_to(196);
        check("over_flag", game_over, 1);
        check("over_lives", lives, 0);
        check("over_y1", ypos1, 31);
        check("over_y2", ypos2, 31);
        check("over_y3", ypos3, 31);
        check("over_l1", letter1, 8'hA9);
        check("over_l2", letter2, 8'h54);
        check("over_l3", letter3, 8'h53);
        pulse(8'h54, 197);
        run_to(240);
        check("frozen_score", score, 2);
        check("frozen_lives", lives, 0);
        check("frozen_flag", game_over, 1);
        check("frozen_y1", ypos1, 31);
        check("frozen_y2", ypos2, 31);
        check("frozen_l2", letter2, 8'h54);
        reset_n = 1'b0;
        #1;
        check_reset("midrst");
        @(negedge clock);
        reset_n = 1'b1;
        edges = 0;
        run_to(4);
        check("reseed_letter", letter1, 8'hA5);
        check("reseed_y1", ypos1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
